// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer capture channel.
// Sample words are {timestamp, sample}; helpers work on a 64-bit container.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    READ
  } la_state_e;

  function automatic int la_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [63:0] la_pack_word(input logic [31:0] ts,
                                               input logic [31:0] sample,
                                               input int          width);
    return ({32'd0, ts} << width) | {32'd0, sample};
  endfunction

  function automatic logic [31:0] la_unpack_ts(input logic [63:0] word,
                                               input int          width);
    return 32'(word >> width);
  endfunction

  function automatic logic [31:0] la_unpack_sample(input logic [63:0] word,
                                                   input int          width);
    logic [63:0] m;
    m = (64'd1 << width) - 64'd1;
    return 32'(word & m);
  endfunction

endpackage

// File: rtl/la_ring_buffer.sv
// Simple dual-port capture memory: one write port, one registered read port.
// No reset on the array so it maps onto block RAM.
module la_ring_buffer
  import la_pkg::*;
#(
  parameter int  DW    = 24,
  parameter int  DEPTH = 64,
  localparam int AW    = la_addr_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_q <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture channel: prescaled sampling into a ring buffer,
// masked level/edge trigger, then oldest-first readout over valid/ready.
module la_capture_core
  import la_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 64,
  parameter int  TS_W  = 16,
  localparam int AW    = la_addr_width(DEPTH),
  localparam int DW    = TS_W + WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_arm,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_trig_mask,
  input  logic [WIDTH-1:0] i_trig_value,
  input  logic             i_trig_edge,
  input  logic [AW-1:0]    i_pre_count,
  input  logic [15:0]      i_prescale,
  output logic             o_run,
  output logic             o_triggered,
  output logic             o_done,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [DW-1:0]    o_rd_data
);

  la_state_e        r_state;
  logic [WIDTH-1:0] r_mask, r_value;
  logic             r_edge;
  logic [AW-1:0]    r_pre;
  logic [15:0]      r_prescale, r_psc;
  logic [TS_W-1:0]  r_ts;
  logic [AW-1:0]    r_wr_ptr;
  logic             r_prev_match;
  logic [AW:0]      r_cnt;
  logic             r_run, r_done, r_triggered;

  logic [AW-1:0]    r_rd_addr;
  logic [AW:0]      r_fetch_left, r_xfer_left;
  logic             r_pending, r_out_valid, r_skid_valid;
  logic [DW-1:0]    r_out_data, r_skid_data;

  logic             w_strobe, w_match, w_fire, w_trig_now, w_rd_start;
  logic [AW:0]      w_post_target, w_cnt_inc;
  logic [DW-1:0]    w_wr_word, w_ram_q;
  logic             w_pop, w_fetch, w_out_free;
  logic [1:0]       w_occ;

  assign w_strobe      = r_run && (r_psc == r_prescale);
  assign w_match       = ((i_data ^ r_value) & r_mask) == '0;
  // An all-zero mask always matches, so there is never a not-match -> match entry.
  assign w_fire        = r_edge ? (w_match && !r_prev_match && (r_mask != '0)) : w_match;
  assign w_post_target = (AW+1)'(DEPTH) - {1'b0, r_pre};
  assign w_cnt_inc     = r_cnt + (AW+1)'(1);
  assign w_trig_now    = (r_state == WAIT_TRIG) && w_strobe && w_fire;
  assign w_rd_start    = (w_trig_now && (w_post_target == (AW+1)'(1))) ||
                         ((r_state == POST) && w_strobe && (w_cnt_inc == w_post_target));
  assign w_wr_word     = DW'(la_pack_word(32'(r_ts), 32'(i_data), WIDTH));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_state      <= IDLE;
      r_run        <= 1'b0;
      r_done       <= 1'b0;
      r_triggered  <= 1'b0;
      r_psc        <= '0;
      r_ts         <= '0;
      r_wr_ptr     <= '0;
      r_prev_match <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_strobe) begin
        r_psc        <= '0;
        r_ts         <= r_ts + TS_W'(1);
        r_wr_ptr     <= r_wr_ptr + AW'(1);
        r_prev_match <= w_match;
      end else if (r_run) begin
        r_psc <= r_psc + 16'd1;
      end

      case (r_state)
        IDLE: begin
          if (i_arm) begin
            r_mask       <= i_trig_mask;
            r_value      <= i_trig_value;
            r_edge       <= i_trig_edge;
            r_pre        <= i_pre_count;
            r_prescale   <= i_prescale;
            r_psc        <= '0;
            r_ts         <= '0;
            r_wr_ptr     <= '0;
            r_prev_match <= 1'b0;
            r_cnt        <= '0;
            r_run        <= 1'b1;
            r_state      <= (i_pre_count == '0) ? WAIT_TRIG : PREFILL;
          end
        end
        PREFILL: begin
          if (w_strobe) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == {1'b0, r_pre}) r_state <= WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (w_trig_now) begin
            r_triggered <= 1'b1;
            r_cnt       <= (AW+1)'(1);
            r_state     <= POST;
          end
        end
        POST: begin
          if (w_strobe) r_cnt <= w_cnt_inc;
        end
        READ: begin
          if (w_pop && (r_xfer_left == (AW+1)'(1))) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_triggered <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_rd_start) begin
        r_state <= READ;
        r_run   <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  // Readout: output register plus one skid slot; a fetch is issued only when
  // the word it returns is guaranteed a slot, so the RAM never stalls.
  assign w_pop      = r_out_valid && i_rd_ready;
  assign w_out_free = !r_out_valid || w_pop;
  assign w_occ      = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_pending) - 2'(w_pop);
  assign w_fetch    = (r_state == READ) && (r_fetch_left != '0) && (w_occ < 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_rd_addr    <= '0;
      r_fetch_left <= '0;
      r_xfer_left  <= '0;
      r_pending    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (w_rd_start) begin
      r_rd_addr    <= r_wr_ptr + AW'(1);
      r_fetch_left <= (AW+1)'(DEPTH);
      r_xfer_left  <= (AW+1)'(DEPTH);
      r_pending    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_state == READ) begin
      r_pending <= w_fetch;
      if (w_fetch) begin
        r_rd_addr    <= r_rd_addr + AW'(1);
        r_fetch_left <= r_fetch_left - (AW+1)'(1);
      end
      if (w_pop) r_xfer_left <= r_xfer_left - (AW+1)'(1);

      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_data   <= r_skid_data;
          r_out_valid  <= 1'b1;
          r_skid_valid <= r_pending;
          if (r_pending) r_skid_data <= w_ram_q;
        end else if (r_pending) begin
          r_out_data  <= w_ram_q;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (r_pending) begin
        r_skid_data  <= w_ram_q;
        r_skid_valid <= 1'b1;
      end
    end else begin
      r_pending    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end
  end

  la_ring_buffer #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ring (
    .i_clk     (i_clk),
    .i_wr_en   (w_strobe),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_fetch),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_ram_q)
  );

  assign o_run       = r_run;
  assign o_done      = r_done;
  assign o_triggered = r_triggered;
  assign o_rd_valid  = r_out_valid;
  assign o_rd_data   = r_out_data;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core: per-clock data tables, a strobe-level capture
// model that predicts the trigger and the 16 readout words, and protocol checks.
module tb_la_capture_core;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int TS_W  = 8;
  localparam int NCLK  = 1024;

  logic        clk = 1'b0;
  logic        i_rst, i_arm, i_abort, i_trig_edge, i_rd_ready;
  logic [7:0]  i_data, i_trig_mask, i_trig_value;
  logic [3:0]  i_pre_count;
  logic [15:0] i_prescale;
  logic        o_run, o_triggered, o_done, o_rd_valid;
  logic [15:0] o_rd_data;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  g_arr [NCLK];

  always #5 clk = ~clk;

  la_capture_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_arm        (i_arm),
    .i_abort      (i_abort),
    .i_trig_mask  (i_trig_mask),
    .i_trig_value (i_trig_value),
    .i_trig_edge  (i_trig_edge),
    .i_pre_count  (i_pre_count),
    .i_prescale   (i_prescale),
    .o_run        (o_run),
    .o_triggered  (o_triggered),
    .o_done       (o_done),
    .o_rd_valid   (o_rd_valid),
    .i_rd_ready   (i_rd_ready),
    .o_rd_data    (o_rd_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Per-clock data after arm; clock j feeds strobe j/(p+1) when j%(p+1)==p.
  task automatic fill_arr(input int mode, input int p);
    for (int j = 0; j < NCLK; j++) begin
      int si;
      si = j / (p + 1);
      case (mode)
        0:       g_arr[j] = 8'(si);
        1:       g_arr[j] = 8'h2A;
        2:       g_arr[j] = (si < 10 || si >= 15) ? 8'h2A : 8'h00;
        default: g_arr[j] = 8'($urandom);
      endcase
    end
  endtask

  function automatic logic [7:0] sample_at(input int k, input int p);
    int idx;
    idx = k * (p + 1) + p;
    return (idx < NCLK) ? g_arr[idx] : 8'h00;
  endfunction

  // First strobe index that triggers, or -1 if none within the table.
  function automatic int find_trig(input int pre, input int p, input logic [7:0] mask,
                                   input logic [7:0] value, input logic edge_m);
    logic pm;
    pm = 1'b0;
    for (int k = 0; k * (p + 1) + p < NCLK; k++) begin
      logic m;
      m = ((sample_at(k, p) ^ value) & mask) == 8'h00;
      if (k >= pre) begin
        if (edge_m ? (mask != 8'h00 && m && !pm) : m) return k;
      end
      pm = m;
    end
    return -1;
  endfunction

  task automatic check_idle(input string tag, input bit with_data);
    check_eq({tag, "_run"},   32'(o_run),       32'd0);
    check_eq({tag, "_done"},  32'(o_done),      32'd0);
    check_eq({tag, "_trig"},  32'(o_triggered), 32'd0);
    check_eq({tag, "_valid"}, 32'(o_rd_valid),  32'd0);
    if (with_data) check_eq({tag, "_data"}, 32'(o_rd_data), 32'd0);
  endtask

  task automatic idle_watch(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen = seen | o_rd_valid | o_run;
    end
    check_eq({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  task automatic run_capture(input string name, input int pre, input int p,
                             input logic [7:0] mask, input logic [7:0] value,
                             input logic edge_m, input int rdy_mode, input int abort_at,
                             input int rst_after, input int glitch_at);
    int          t, lst, tcyc, dcyc, xfers, first_x, last_x;
    logic [15:0] exp_w [DEPTH];
    logic        stall;
    logic [15:0] stall_data;
    t = find_trig(pre, p, mask, value, edge_m);
    if (t >= 0) begin
      lst  = t + DEPTH - pre - 1;
      tcyc = t * (p + 1) + p + 1;
      dcyc = lst * (p + 1) + p + 1;
      for (int i = 0; i < DEPTH; i++) exp_w[i] = {8'(t - pre + i), sample_at(t - pre + i, p)};
    end else begin
      tcyc = 1 << 30;
      dcyc = 1 << 30;
      for (int i = 0; i < DEPTH; i++) exp_w[i] = 16'h0000;
      if (abort_at < 0) abort_at = 400;
    end
    $display("capture %s: pre=%0d prescale=%0d mask=%h value=%h edge=%0d trig_strobe=%0d",
             name, pre, p, mask, value, edge_m, t);
    i_trig_mask = mask; i_trig_value = value; i_trig_edge = edge_m;
    i_pre_count = 4'(pre); i_prescale = 16'(p); i_arm = 1'b1; i_rd_ready = 1'b0;
    @(negedge clk);
    i_arm = 1'b0;
    // Configuration must have been latched at arm; scramble the inputs now.
    i_trig_mask = 8'($urandom); i_trig_value = 8'($urandom); i_trig_edge = 1'($urandom);
    i_pre_count = 4'($urandom); i_prescale = 16'($urandom);
    xfers = 0; stall = 1'b0; stall_data = '0; first_x = -1; last_x = -1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      i_data = (cyc < NCLK) ? g_arr[cyc] : 8'h00;
      i_arm  = (cyc == glitch_at);
      check_eq({name, "_run"},  32'(o_run),       32'(cyc < dcyc));
      check_eq({name, "_done"}, 32'(o_done),      32'(cyc >= dcyc));
      check_eq({name, "_trig"}, 32'(o_triggered), 32'(cyc >= tcyc));
      if (cyc < dcyc) check_eq({name, "_valid_early"}, 32'(o_rd_valid), 32'd0);
      if (cyc == dcyc + 2) check_eq({name, "_valid_latency"}, 32'(o_rd_valid), 32'd1);
      if (cyc == abort_at) begin
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check_idle({name, "_abort"}, 1'b1);
        idle_watch(name, 30);
        return;
      end
      if (cyc >= dcyc) begin
        if (stall) begin
          check_eq({name, "_stall_valid"}, 32'(o_rd_valid), 32'd1);
          check_eq({name, "_stall_data"},  32'(o_rd_data),  32'(stall_data));
        end
        if (rst_after > 0 && xfers == rst_after) begin
          i_rst = 1'b1; i_rd_ready = 1'b0;
          @(negedge clk);
          i_rst = 1'b0;
          check_idle({name, "_reset"}, 1'b1);
          idle_watch(name, 30);
          return;
        end
        i_rd_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        stall      = o_rd_valid && !i_rd_ready;
        stall_data = o_rd_data;
        if (o_rd_valid && i_rd_ready) begin
          check_eq($sformatf("%s_word%0d", name, xfers), 32'(o_rd_data), 32'(exp_w[xfers]));
          $display("xfer %s #%0d: data=%h expected=%h", name, xfers, o_rd_data, exp_w[xfers]);
          if (first_x < 0) first_x = cyc;
          last_x = cyc;
          xfers++;
          if (xfers == DEPTH) begin
            @(negedge clk);
            i_rd_ready = 1'b0;
            check_idle({name, "_end"}, 1'b0);
            if (rdy_mode == 0) check_eq({name, "_throughput"}, 32'(last_x - first_x), 32'(DEPTH - 1));
            return;
          end
        end
      end
      @(negedge clk);
    end
    check_eq({name, "_timeout_xfers"}, 32'(xfers), 32'(DEPTH));
    i_rd_ready = 1'b0; i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_arm = 1'b0; i_abort = 1'b0; i_trig_edge = 1'b0; i_rd_ready = 1'b0;
    i_data = 8'h00; i_trig_mask = 8'h00; i_trig_value = 8'h00; i_pre_count = 4'd0; i_prescale = 16'd0;
    repeat (3) @(negedge clk);
    check_idle("reset_state", 1'b1);
    i_rst = 1'b0;
    @(negedge clk);

    fill_arr(0, 0); run_capture("level_ramp",   4, 0, 8'hFF, 8'h2A, 1'b0, 0, -1, -1, 20);
    fill_arr(1, 0); run_capture("level_const",  4, 0, 8'hFF, 8'h2A, 1'b0, 0, -1, -1, -1);
    fill_arr(2, 0); run_capture("edge",         4, 0, 8'hFF, 8'h2A, 1'b1, 0, -1, -1, -1);
    fill_arr(3, 3); run_capture("prescale3",    4, 3, 8'h00, 8'h00, 1'b0, 0, -1, -1, -1);
    fill_arr(3, 1); run_capture("backpressure", 2, 1, 8'h03, 8'h01, 1'b0, 1, -1, -1, -1);
    fill_arr(1, 0); run_capture("abort_post",   4, 0, 8'hFF, 8'h2A, 1'b0, 0, 8, -1, -1);

    // Arm and abort together: abort wins.
    i_trig_mask = 8'h00; i_pre_count = 4'd0; i_prescale = 16'd0; i_arm = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_arm = 1'b0; i_abort = 1'b0;
    check_idle("arm_abort", 1'b1);
    idle_watch("arm_abort", 20);

    fill_arr(0, 0); run_capture("rearm",        4, 0, 8'hFF, 8'h2A, 1'b0, 0, -1, -1, -1);
    fill_arr(0, 0); run_capture("reset_read",   4, 0, 8'hFF, 8'h2A, 1'b0, 0, -1, 5, -1);
    fill_arr(3, 0); run_capture("pre15",       15, 0, 8'h00, 8'h00, 1'b0, 0, -1, -1, -1);
    fill_arr(1, 0); run_capture("edge_mask0",   0, 0, 8'h00, 8'h2A, 1'b1, 0, 100, -1, -1);

    for (int r = 0; r < 4; r++) begin
      int p;
      p = $urandom_range(0, 2);
      fill_arr(3, p);
      run_capture($sformatf("random%0d", r), $urandom_range(0, 15), p, 8'($urandom) & 8'h0F,
                  8'($urandom), 1'($urandom_range(0, 1)), 1, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
